// File: rtl/sound_sequencer_if.sv
// Sound sequencer bus: game-logic event requests in, oscillator drive and
// status out. The master side is the game logic, the slave side is the
// sequencer.
interface sound_sequencer_if;
  logic       req_eat;
  logic       req_start;
  logic       req_crash;
  logic [7:0] freq;
  logic       state;
  logic       playSound;
  logic       busy;
  logic [1:0] active_id;
  logic       done;

  modport master (
    output req_eat, req_start, req_crash,
    input  freq, state, playSound, busy, active_id, done
  );

  modport slave (
    input  req_eat, req_start, req_crash,
    output freq, state, playSound, busy, active_id, done
  );
endinterface

// File: rtl/sound_sequencer.sv
// Sound-effect sequencer for the Snakes audio path. Arbitrates eat/start/crash
// requests (crash > start > eat), remembers requests that arrive while busy,
// and plays each event as a fixed melody of timed notes separated by gaps.
// Optional build macro: SOUND_PREEMPT_EN -- a crash request aborts an eat or
// start melody and starts the crash melody at the next edge.
module sound_sequencer #(
  parameter int NOTE_CYCLES = 50000,
  parameter int GAP_CYCLES  = 5000
) (
  input  logic             clk,
  input  logic             nRst,
  sound_sequencer_if.slave io_snd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [15:0] NOTE_LAST = 16'(NOTE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [1:0]  ID_NONE   = 2'd0;
  localparam logic [1:0]  ID_EAT    = 2'd1;
  localparam logic [1:0]  ID_START  = 2'd2;
  localparam logic [1:0]  ID_CRASH  = 2'd3;

  // Melody ROM: half-period count for note idx of melody id.
  function automatic logic [7:0] note_freq(input logic [1:0] id, input logic [1:0] idx);
    logic [7:0] f;
    f = 8'd0;
    case ({id, idx})
      4'b0100: f = 8'd40;
      4'b0101: f = 8'd30;
      4'b1000: f = 8'd60;
      4'b1001: f = 8'd80;
      4'b1010: f = 8'd100;
      4'b1100: f = 8'd200;
      4'b1101: f = 8'd180;
      4'b1110: f = 8'd160;
      4'b1111: f = 8'd120;
      default: f = 8'd0;
    endcase
    return f;
  endfunction

  // Index of the final note of each melody.
  function automatic logic [1:0] last_idx(input logic [1:0] id);
    logic [1:0] l;
    l = 2'd0;
    case (id)
      ID_EAT:   l = 2'd1;
      ID_START: l = 2'd2;
      ID_CRASH: l = 2'd3;
      default:  l = 2'd0;
    endcase
    return l;
  endfunction

  state_t      r_state, w_state;
  logic [1:0]  r_id, w_id;
  logic [1:0]  r_idx, w_idx;
  logic [15:0] r_cnt, w_cnt;
  logic [2:0]  r_pend, w_pend;     // {crash, start, eat}
  logic        w_done;
  logic [2:0]  w_req;
  logic [2:0]  w_cand;
  logic        w_preempt;

  logic [7:0]  r_freq;
  logic        r_on;
  logic        r_play;
  logic        r_busy;
  logic [1:0]  r_active;
  logic        r_done;

  assign w_req  = {io_snd.req_crash, io_snd.req_start, io_snd.req_eat};
  assign w_cand = w_req | r_pend;

`ifdef SOUND_PREEMPT_EN
  assign w_preempt = (r_state != S_IDLE) && io_snd.req_crash &&
                     ((r_id == ID_EAT) || (r_id == ID_START));
`else
  assign w_preempt = 1'b0;
`endif

  // Next-state logic: arbitration in IDLE, note/gap timing, pending capture.
  always_comb begin
    w_state = r_state;
    w_id    = r_id;
    w_idx   = r_idx;
    w_cnt   = r_cnt;
    w_pend  = r_pend;
    w_done  = 1'b0;
    if (w_preempt) begin
      // Aborted melody is dropped; the crash starts now so its bit stays clear.
      w_state = S_PLAY;
      w_id    = ID_CRASH;
      w_idx   = 2'd0;
      w_cnt   = 16'd0;
      w_pend  = (r_pend | w_req) & 3'b011;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cand != 3'b000) begin
            w_state = S_PLAY;
            w_idx   = 2'd0;
            w_cnt   = 16'd0;
            if (w_cand[2]) begin
              w_id   = ID_CRASH;
              w_pend = w_cand & 3'b011;
            end else if (w_cand[1]) begin
              w_id   = ID_START;
              w_pend = w_cand & 3'b101;
            end else begin
              w_id   = ID_EAT;
              w_pend = w_cand & 3'b110;
            end
          end else begin
            w_id = ID_NONE;
          end
        end
        S_PLAY: begin
          w_pend = r_pend | w_req;
          if (r_cnt == NOTE_LAST) begin
            w_cnt = 16'd0;
            if (r_idx == last_idx(r_id)) begin
              w_state = S_IDLE;
              w_id    = ID_NONE;
              w_idx   = 2'd0;
              w_done  = 1'b1;
            end else begin
              w_state = S_GAP;
            end
          end else begin
            w_cnt = r_cnt + 16'd1;
          end
        end
        S_GAP: begin
          w_pend = r_pend | w_req;
          if (r_cnt == GAP_LAST) begin
            w_cnt   = 16'd0;
            w_idx   = r_idx + 2'd1;
            w_state = S_PLAY;
          end else begin
            w_cnt = r_cnt + 16'd1;
          end
        end
        default: begin
          w_state = S_IDLE;
          w_id    = ID_NONE;
          w_idx   = 2'd0;
          w_cnt   = 16'd0;
          w_pend  = 3'b000;
        end
      endcase
    end
  end

  // State register plus outputs registered from the next state.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state  <= S_IDLE;
      r_id     <= ID_NONE;
      r_idx    <= 2'd0;
      r_cnt    <= 16'd0;
      r_pend   <= 3'b000;
      r_freq   <= 8'd0;
      r_on     <= 1'b0;
      r_play   <= 1'b0;
      r_busy   <= 1'b0;
      r_active <= ID_NONE;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_id     <= w_id;
      r_idx    <= w_idx;
      r_cnt    <= w_cnt;
      r_pend   <= w_pend;
      r_freq   <= (w_state == S_IDLE) ? 8'd0 : note_freq(w_id, w_idx);
      r_on     <= (w_state != S_IDLE);
      r_play   <= (w_state == S_PLAY);
      r_busy   <= (w_state != S_IDLE);
      r_active <= (w_state == S_IDLE) ? ID_NONE : w_id;
      r_done   <= w_done;
    end
  end

  assign io_snd.freq      = r_freq;
  assign io_snd.state     = r_on;
  assign io_snd.playSound = r_play;
  assign io_snd.busy      = r_busy;
  assign io_snd.active_id = r_active;
  assign io_snd.done      = r_done;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed, table-driven bench for sound_sequencer with NOTE_CYCLES=4,
// GAP_CYCLES=2. Honours SOUND_PREEMPT_EN for the crash-preemption scenario.
module tb_sound_sequencer;

  localparam int NC = 4;
  localparam int GC = 2;

  typedef struct packed {
    logic [7:0] freq;
    logic       on;
    logic       play;
    logic       busy;
    logic [1:0] id;
    logic       done;
  } exp_t;

  typedef struct {
    logic [2:0] req;   // {crash, start, eat}
    exp_t       exp;
  } vec_t;

  logic clk;
  logic nRst;
  int   errors;
  int   checks;

  sound_sequencer_if snd ();

  sound_sequencer #(.NOTE_CYCLES(NC), .GAP_CYCLES(GC)) dut (
    .clk    (clk),
    .nRst   (nRst),
    .io_snd (snd.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int note_of(input int id, input int k);
    int f;
    f = 0;
    case (id)
      1: f = (k == 0) ? 40 : 30;
      2: f = (k == 0) ? 60 : (k == 1) ? 80 : 100;
      3: f = (k == 0) ? 200 : (k == 1) ? 180 : (k == 2) ? 160 : 120;
      default: f = 0;
    endcase
    return f;
  endfunction

  function automatic int mel_len(input int id);
    int n;
    n = id + 1;
    return n * NC + (n - 1) * GC;
  endfunction

  // Expected outputs t cycles into a melody (t = 0 is the first busy cycle).
  function automatic exp_t model(input int id, input int t);
    exp_t e;
    int   k;
    int   r;
    k      = t / (NC + GC);
    r      = t % (NC + GC);
    e.freq = 8'(note_of(id, k));
    e.on   = 1'b1;
    e.play = (r < NC);
    e.busy = 1'b1;
    e.id   = 2'(id);
    e.done = 1'b0;
    return e;
  endfunction

  exp_t idle_e;
  exp_t done_e;

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input exp_t e);
    chk({name, ".freq"},      int'(snd.freq),      int'(e.freq));
    chk({name, ".state"},     int'(snd.state),     int'(e.on));
    chk({name, ".playSound"}, int'(snd.playSound), int'(e.play));
    chk({name, ".busy"},      int'(snd.busy),      int'(e.busy));
    chk({name, ".active_id"}, int'(snd.active_id), int'(e.id));
    chk({name, ".done"},      int'(snd.done),      int'(e.done));
  endtask

  // Drive requests for one cycle and sample just after the following edge.
  task automatic tick(input logic [2:0] req);
    @(negedge clk);
    snd.req_crash = req[2];
    snd.req_start = req[1];
    snd.req_eat   = req[0];
    @(posedge clk);
    #1;
  endtask

  // Check a whole melody cycle by cycle; req is driven for offsets lo..hi.
  task automatic run_melody(input string name, input int id, input logic [2:0] req,
                            input int lo, input int hi);
    for (int t = 0; t < mel_len(id); t++) begin
      check_out($sformatf("%s[%0d]", name, t), model(id, t));
      tick((t >= lo && t <= hi) ? req : 3'b000);
    end
  endtask

  vec_t eat_tab [12];

  initial begin
    errors = 0;
    checks = 0;
    idle_e = '0;
    done_e = '0;
    done_e.done = 1'b1;
    nRst = 1'b0;
    snd.req_eat = 1'b0;
    snd.req_start = 1'b0;
    snd.req_crash = 1'b0;

    eat_tab[0]  = '{3'b001, '{8'd40, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0}};
    eat_tab[1]  = '{3'b000, '{8'd40, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0}};
    eat_tab[2]  = '{3'b000, '{8'd40, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0}};
    eat_tab[3]  = '{3'b000, '{8'd40, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0}};
    eat_tab[4]  = '{3'b000, '{8'd40, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0}};
    eat_tab[5]  = '{3'b000, '{8'd40, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0}};
    eat_tab[6]  = '{3'b000, '{8'd30, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0}};
    eat_tab[7]  = '{3'b000, '{8'd30, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0}};
    eat_tab[8]  = '{3'b000, '{8'd30, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0}};
    eat_tab[9]  = '{3'b000, '{8'd30, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0}};
    eat_tab[10] = '{3'b000, '{8'd0,  1'b0, 1'b0, 1'b0, 2'd0, 1'b1}};
    eat_tab[11] = '{3'b000, '{8'd0,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0}};

    // Reset held with requests active: outputs stay at reset values.
    tick(3'b111);
    check_out("rst_hold0", idle_e);
    tick(3'b111);
    check_out("rst_hold1", idle_e);
    @(negedge clk);
    snd.req_crash = 1'b0;
    snd.req_start = 1'b0;
    snd.req_eat   = 1'b0;
    nRst = 1'b1;
    tick(3'b000);
    check_out("idle0", idle_e);
    tick(3'b000);
    check_out("idle1", idle_e);

    // Single eat melody from the vector table.
    for (int i = 0; i < 12; i++) begin
      tick(eat_tab[i].req);
      check_out($sformatf("eat[%0d]", i), eat_tab[i].exp);
    end

    // Simultaneous eat + start: start first, eat after one idle cycle.
    tick(3'b011);
    run_melody("sim_start", 2, 3'b000, -1, -1);
    check_out("sim_start_done", done_e);
    tick(3'b000);
    run_melody("sim_eat", 1, 3'b000, -1, -1);
    check_out("sim_eat_done", done_e);
    tick(3'b000);
    check_out("sim_idle", idle_e);

    // Eat held 3 cycles during start: exactly one eat melody follows.
    tick(3'b010);
    run_melody("busy_start", 2, 3'b001, 2, 4);
    check_out("busy_start_done", done_e);
    tick(3'b000);
    run_melody("busy_eat", 1, 3'b000, -1, -1);
    check_out("busy_eat_done", done_e);
    for (int i = 0; i < 3; i++) begin
      tick(3'b000);
      check_out($sformatf("busy_after[%0d]", i), idle_e);
    end

    // Start at cycle 0, crash at cycle 6.
    tick(3'b010);
    for (int t = 0; t < 6; t++) begin
      check_out($sformatf("pre_start[%0d]", t), model(2, t));
      tick((t == 5) ? 3'b100 : 3'b000);
    end
`ifdef SOUND_PREEMPT_EN
    run_melody("pre_crash", 3, 3'b000, -1, -1);
    check_out("pre_crash_done", done_e);
`else
    for (int t = 6; t < mel_len(2); t++) begin
      check_out($sformatf("pre_start[%0d]", t), model(2, t));
      tick(3'b000);
    end
    check_out("pre_start_done", done_e);
    tick(3'b000);
    run_melody("pre_crash", 3, 3'b000, -1, -1);
    check_out("pre_crash_done", done_e);
`endif
    tick(3'b000);
    check_out("pre_idle", idle_e);

    // Reset during crash note 2 with an eat pending: everything cleared.
    tick(3'b100);
    for (int t = 0; t < 13; t++) begin
      check_out($sformatf("mr_crash[%0d]", t), model(3, t));
      tick((t == 3) ? 3'b001 : 3'b000);
    end
    check_out("mr_crash[13]", model(3, 13));
    #2;
    nRst = 1'b0;
    #1;
    check_out("mr_async", idle_e);
    @(negedge clk);
    check_out("mr_held", idle_e);
    nRst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(3'b000);
      check_out($sformatf("mr_after[%0d]", i), idle_e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Sound-effect sequencer for the Snakes game audio path. Accepts one-cycle event requests from game logic (eat, start, crash), arbitrates them by fixed priority, and plays each event as a fixed short melody. It drives the square-wave oscillator's `freq`, `state` and `playSound` inputs note by note, with timed notes and inter-note gaps.

## Interface
Parameters:
- `NOTE_CYCLES`, default 50000: clk cycles each note is sounded. Range 1..65535.
- `GAP_CYCLES`, default 5000: silent clk cycles between consecutive notes of one melody. Range 1..65535.

Ports:
- `clk`  in  1  system clock
- `nRst`  in  1  reset, asynchronous, active-low
- `req_eat`  in  1  eat event request, level sampled each clk edge
- `req_start`  in  1  game-start event request
- `req_crash`  in  1  crash / game-over event request
- `freq`  out  8  oscillator half-period count for the current note
- `state`  out  1  oscillator mode (MODE_TYPES): 1 = ON, 0 = OFF
- `playSound`  out  1  oscillator enable, high only while a note sounds
- `busy`  out  1  high while a melody is in progress
- `active_id`  out  2  melody in progress: 0 none, 1 eat, 2 start, 3 crash
- `done`  out  1  one-cycle pulse when a melody completes naturally

## Operation
- Melody ROM, fixed:
  - eat: 40, 30
  - start: 60, 80, 100
  - crash: 200, 180, 160, 120
- Priority: crash > start > eat.
- Pending register: 3 bits, one per event.
  - A request high while `busy` sets its pending bit, including a request for the id now playing.
  - A pending bit clears when its melody starts.
- FSM states: IDLE, PLAY, GAP.
- IDLE:
  - Candidates = live requests OR pending bits.
  - If any candidate exists, load the highest-priority one. Next state is PLAY, note 0. The chosen id's pending bit clears; all other candidates are written to pending.
- PLAY: note counter counts NOTE_CYCLES cycles. When it expires:
  - If more notes remain, go to GAP.
  - Otherwise go to IDLE and pulse `done`.
- GAP: counter counts GAP_CYCLES cycles, then the note index increments and the FSM returns to PLAY.
- Outputs by state:
  - IDLE: `freq`=0, `state`=OFF, `playSound`=0, `busy`=0, `active_id`=0.
  - PLAY: `freq` = current note, `state`=ON, `playSound`=1, `busy`=1.
  - GAP: as PLAY, but `playSound`=0. `freq` holds the previous note.
- Counters are 16 bits wide and count from 0 to N-1. Note index is 2 bits and never wraps: the last-note check ends the melody.

## Timing
- All outputs are registered.
- Reset values: `freq`=0, `state`=OFF, `playSound`=0, `busy`=0, `active_id`=0, `done`=0. Pending bits clear, FSM is IDLE, counters are 0.
- Latency: a request high in IDLE at edge k gives `playSound`=1 in the cycle after edge k.
- Melody length: notes×NOTE_CYCLES + (notes−1)×GAP_CYCLES busy cycles.
- `done` is high in the first IDLE cycle after the last note.
  - In that same cycle, pending candidates are evaluated. The next melody sounds one cycle later, giving one idle cycle between back-to-back melodies.
- Simultaneous requests in IDLE: the highest priority plays and the others go to pending, served later in priority order.
- Reset asserted mid-melody: all outputs go to reset values immediately (asynchronous). Pending bits are lost.
- Requests are levels. A request held high for multiple cycles while busy sets its pending bit once; it does not queue a count.

## Configuration
- `SOUND_PREEMPT_EN` defined: `req_crash` while `active_id` is 1 or 2 aborts the current melody at the next edge.
  - The FSM enters PLAY with crash note 0 and counters reset.
  - The aborted melody is discarded: no `done`, pending bit not re-set.
  - Crash during crash is latched to pending as usual.
- `SOUND_PREEMPT_EN` undefined: no preemption. Crash is latched to pending like any other request.

## Test plan
Test parameters: NOTE_CYCLES=4, GAP_CYCLES=2.
- Reset then idle: all outputs 0 / OFF. Any stimulus with `nRst` low leaves all outputs 0.
- Single eat: `req_eat` pulse in cycle 0 → cycles 1-4 `freq`=40, `playSound`=1 → cycles 5-6 `freq`=40, `playSound`=0 → cycles 7-10 `freq`=30, `playSound`=1 → cycle 11 IDLE, `done`=1, `busy`=0.
- Simultaneous: `req_eat` and `req_start` both pulsed in cycle 0.
  - Start melody plays (`active_id`=2, freqs 60/80/100), `done` in cycle 17.
  - Eat plays next, starting cycle 18.
- Request while busy: `req_eat` pulsed during the start melody, held 3 cycles → exactly one eat melody follows the start melody.
- Preempt, with `SOUND_PREEMPT_EN`: `req_start` at cycle 0, `req_crash` at cycle 6.
  - Cycle 7: `freq`=200, `active_id`=3.
  - No `done` for start. Crash `done` arrives in cycle 29.
- Preempt, without `SOUND_PREEMPT_EN`: same stimulus → start completes with `done` in cycle 17, and crash begins in cycle 18.
- Mid-melody reset: `nRst` low during crash note 2 → outputs 0 immediately. After release, the FSM stays IDLE with no residual pending.
